uart_tx_fifo: RTL

Byte buffer and launch controller upstream of the UART transmitter. Accepts bytes from on-chip logic into a DEPTH-entry circular FIFO. Drains them one at a time into the transmitter through its data/start/busy handshake, holding each byte stable for the full frame. Lets producers burst bytes without tracking transmitter state.

---
 rtl/uart_tx_fifo_if.sv | 26 ++
 rtl/uart_tx_fifo.sv | 109 ++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Producer/transmitter-side bundle for uart_tx_fifo: byte enqueue, FIFO status and the
// transmitter data/start/busy handshake. slave is the buffer block, master its environment.
interface uart_tx_fifo_if #(
    parameter int AW = 4
);
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        full;
    logic        empty;
    logic [AW:0] count;
    logic        overflow;
    logic [7:0]  tx_data;
    logic        tx_start_n;
    logic        tx_busy;
    logic        active;

    modport master (
        output wr_data, wr_en, tx_busy,
        input  full, empty, count, overflow, tx_data, tx_start_n, active
    );

    modport slave (
        input  wr_data, wr_en, tx_busy,
        output full, empty, count, overflow, tx_data, tx_start_n, active
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// DEPTH-byte circular FIFO feeding a UART transmitter; write-to-start latency 2 edges.
// Writes while full are dropped (sticky overflow); launches wait for tx_busy low, no timeout.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_tx_fifo_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        SEND   = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic [7:0]    tx_data_q;
    logic          tx_start_n_q;
    logic          overflow_q;

    logic full_w;
    logic empty_w;
    logic do_wr;
    logic do_pop;

    // Flags decode the registered count, so a write while full is dropped even if a pop
    // happens on the same edge.
    assign full_w  = (cnt == FULL_CNT);
    assign empty_w = (cnt == '0);
    assign do_wr   = bus.wr_en && !full_w;
    assign do_pop  = (state == IDLE) && !empty_w && !bus.tx_busy;

    always_ff @(posedge clk) begin
        if (rst_n && do_wr) begin
            mem[wptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            tx_start_n_q <= 1'b1;
            tx_data_q    <= 8'h00;
            wptr         <= '0;
            rptr         <= '0;
            cnt          <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (bus.wr_en && full_w) begin
                overflow_q <= 1'b1;
            end
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr      <= rptr + 1'b1;
                tx_data_q <= mem[rptr];
            end
            case ({do_wr, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase

            // Start is released only after busy is seen, and never reasserted outside
            // LAUNCH, so a transmitter returning to idle cannot trigger a second frame.
            case (state)
                IDLE: begin
                    tx_start_n_q <= 1'b1;
                    if (do_pop) begin
                        state        <= LAUNCH;
                        tx_start_n_q <= 1'b0;
                    end
                end
                LAUNCH: begin
                    if (bus.tx_busy) begin
                        state        <= SEND;
                        tx_start_n_q <= 1'b1;
                    end
                end
                SEND: begin
                    tx_start_n_q <= 1'b1;
                    if (!bus.tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    tx_start_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.full       = full_w;
    assign bus.empty      = empty_w;
    assign bus.count      = cnt;
    assign bus.overflow   = overflow_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_start_n = tx_start_n_q;
    assign bus.active     = (state != IDLE);
endmodule
